// File: rtl/ecc_pkg.sv
// Shared definitions for the EC decryption engine: controller states,
// point-unit op codes and the point-negation helper.
package ecc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DBL   = 2'd1,
    S_ADD   = 2'd2,
    S_FINAL = 2'd3
  } state_e;

  typedef enum logic {
    OP_ADD    = 1'b0,
    OP_DOUBLE = 1'b1
  } op_e;

  // Widest field element the negation helper accepts.
  localparam int MAX_N = 64;

  // -(X,Y,Z) = (X, X^Y, Z); only Y changes, so this returns the new Y.
  function automatic logic [MAX_N-1:0] neg_y(input logic [MAX_N-1:0] x,
                                             input logic [MAX_N-1:0] y);
    return x ^ y;
  endfunction

endpackage

// File: rtl/ecc_decrypt_core_ec_point_unit.sv
// Combinational projective point add/double on y^2+xy = x^3+x^2+b over GF(2^N).
// Infinity (Z==0) operands and the P==Q / P==-Q cases are resolved here.
module ec_point_unit
  import ecc_pkg::*;
#(
  parameter int         N    = 3,
  parameter logic [N:0] POLY = 4'b1011
) (
  input  op_e          op,
  input  logic [N-1:0] X0,
  input  logic [N-1:0] Y0,
  input  logic [N-1:0] Z0,
  input  logic [N-1:0] X1,
  input  logic [N-1:0] Y1,
  input  logic [N-1:0] Z1,
  output logic [N-1:0] X2,
  output logic [N-1:0] Y2,
  output logic [N-1:0] Z2
);

  function automatic logic [N-1:0] mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    logic [N-1:0] aa;
    r  = '0;
    aa = a;
    for (int k = 0; k < N; k++) begin
      if (b[k]) r = r ^ aa;
      aa = aa[N-1] ? ((aa << 1) ^ POLY[N-1:0]) : (aa << 1);
    end
    return r;
  endfunction

  logic [N-1:0] d_a, d_b, d_e, x2sq, dx, dy, dz;
  logic [N-1:0] a_a, a_b, a_c, b2, b3, a_e, ax, ay, az;

  always_comb begin
    // doubling: lambda = (X^2+YZ)/(XZ)
    x2sq = mul(X0, X0);
    d_a  = x2sq ^ mul(Y0, Z0);
    d_b  = mul(X0, Z0);
    d_e  = mul(d_a, d_a) ^ mul(d_a, d_b) ^ mul(d_b, d_b);
    dx   = mul(d_b, d_e);
    dy   = mul(mul(x2sq, x2sq), d_b) ^ mul(d_a ^ d_b, d_e);
    dz   = mul(mul(d_b, d_b), d_b);
    // addition: lambda = (Y0Z1+Y1Z0)/(X0Z1+X1Z0)
    a_a  = mul(Y0, Z1) ^ mul(Y1, Z0);
    a_b  = mul(X0, Z1) ^ mul(X1, Z0);
    a_c  = mul(Z0, Z1);
    b2   = mul(a_b, a_b);
    b3   = mul(b2, a_b);
    a_e  = mul(mul(a_a, a_a), a_c) ^ mul(mul(a_a, a_b), a_c) ^ b3 ^ mul(b2, a_c);
    ax   = mul(a_b, a_e);
    ay   = mul(a_a, mul(mul(X0, Z1), b2) ^ a_e) ^ ax ^ mul(mul(Y0, Z1), b3);
    az   = mul(b3, a_c);

    X2 = ax;
    Y2 = ay;
    Z2 = az;
    if (op == OP_DOUBLE) begin
      if (Z0 == '0) begin
        X2 = X0; Y2 = Y0; Z2 = Z0;
      end else begin
        X2 = dx; Y2 = dy; Z2 = dz;
      end
    end else if (Z0 == '0) begin
      X2 = X1; Y2 = Y1; Z2 = Z1;
    end else if (Z1 == '0) begin
      X2 = X0; Y2 = Y0; Z2 = Z0;
    end else if (a_b == '0) begin
      // equal x: same point doubles, opposite points cancel to infinity
      if (a_a == '0) begin
        X2 = dx; Y2 = dy; Z2 = dz;
      end else begin
        X2 = '0; Y2 = N'(1); Z2 = '0;
      end
    end
  end

endmodule

// File: rtl/ecc_decrypt_core.sv
// Constant-time ElGamal EC decryption: Plaintext = C2 - d*C1 via MSB-first
// double-and-add, two cycles per key bit, one shared point unit.
module ecc_decrypt_core
  import ecc_pkg::*;
#(
  parameter int         N    = 3,
  parameter int         K    = 4,
  parameter logic [N:0] POLY = 4'b1011
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] d_key,
  input  logic [N-1:0] x_C1,
  input  logic [N-1:0] y_C1,
  input  logic [N-1:0] z_C1,
  input  logic [N-1:0] x_C2,
  input  logic [N-1:0] y_C2,
  input  logic [N-1:0] z_C2,
  output logic [N-1:0] x_Plaintext,
  output logic [N-1:0] y_Plaintext,
  output logic [N-1:0] z_Plaintext,
  output logic         pt_inf,
  output logic         busy,
  output logic         Decryption_ready
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  state_e       state, state_nxt;
  logic [K-1:0] key;
  logic [N-1:0] x_c1, y_c1, z_c1, x_c2, y_c2, z_c2;
  logic [N-1:0] x_q, y_q, z_q, y_qn;
  logic         acc_inf;
  logic [IW-1:0] idx;

  op_e          pu_op;
  logic [N-1:0] p0x, p0y, p0z, p1x, p1y, p1z, rx, ry, rz;

  logic [MAX_N-1:0]   neg_full;
  logic [MAX_N-N-1:0] unused_neg;

  assign neg_full           = neg_y(MAX_N'(x_q), MAX_N'(y_q));
  assign {unused_neg, y_qn} = neg_full;

  ec_point_unit #(.N(N), .POLY(POLY)) u_pu (
    .op(pu_op),
    .X0(p0x), .Y0(p0y), .Z0(p0z),
    .X1(p1x), .Y1(p1y), .Z1(p1z),
    .X2(rx),  .Y2(ry),  .Z2(rz)
  );

  always_comb begin
    state_nxt = state;
    pu_op     = OP_ADD;
    p0x = x_q;  p0y = y_q;  p0z = z_q;
    p1x = x_c1; p1y = y_c1; p1z = z_c1;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DBL;
      S_DBL: begin
        pu_op     = OP_DOUBLE;
        state_nxt = S_ADD;
      end
      S_ADD:   state_nxt = (idx == '0) ? S_FINAL : S_DBL;
      S_FINAL: begin
        // C2 + (-Q)
        p0x = x_c2; p0y = y_c2; p0z = z_c2;
        p1x = x_q;  p1y = y_qn; p1z = z_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      key              <= '0;
      {x_c1, y_c1, z_c1, x_c2, y_c2, z_c2} <= '0;
      {x_q, y_q, z_q}  <= '0;
      acc_inf          <= 1'b0;
      idx              <= '0;
      x_Plaintext      <= '0;
      y_Plaintext      <= '0;
      z_Plaintext      <= '0;
      pt_inf           <= 1'b0;
      busy             <= 1'b0;
      Decryption_ready <= 1'b0;
    end else begin
      state            <= state_nxt;
      Decryption_ready <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          key     <= d_key;
          x_c1 <= x_C1; y_c1 <= y_C1; z_c1 <= z_C1;
          x_c2 <= x_C2; y_c2 <= y_C2; z_c2 <= z_C2;
          acc_inf <= 1'b1;
          idx     <= IW'(K - 1);
          busy    <= 1'b1;
        end
        S_DBL: if (!acc_inf) begin
          x_q <= rx; y_q <= ry; z_q <= rz;
          acc_inf <= (rz == '0);
        end
        S_ADD: begin
          // point-unit result is computed every cycle and only kept on a set bit
          if (key[idx]) begin
            if (acc_inf) begin
              x_q <= x_c1; y_q <= y_c1; z_q <= z_c1;
              acc_inf <= (z_c1 == '0);
            end else begin
              x_q <= rx; y_q <= ry; z_q <= rz;
              acc_inf <= (rz == '0);
            end
          end
          if (idx != '0) idx <= idx - 1'b1;
        end
        S_FINAL: begin
          if (acc_inf && z_c2 == '0) begin
            x_Plaintext <= '0; y_Plaintext <= '0; z_Plaintext <= '0;
            pt_inf <= 1'b1;
          end else if (acc_inf) begin
            x_Plaintext <= x_c2; y_Plaintext <= y_c2; z_Plaintext <= z_c2;
            pt_inf <= 1'b0;
          end else if (z_c2 == '0) begin
            x_Plaintext <= x_q; y_Plaintext <= y_qn; z_Plaintext <= z_q;
            pt_inf <= 1'b0;
          end else begin
            x_Plaintext <= rx; y_Plaintext <= ry; z_Plaintext <= rz;
            pt_inf <= (rz == '0);
          end
          Decryption_ready <= 1'b1;
          busy             <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_decrypt_core.sv
// Self-checking bench: vector table plus corner sequences, results checked
// through an expected-value queue popped on each done pulse.
module tb_ecc_decrypt_core;
  import ecc_pkg::*;

  typedef struct packed { logic [2:0] x, y, z; } pt_t;
  typedef struct packed { pt_t r; logic inf; } exp_t;
  typedef struct { logic [3:0] d; pt_t c1, c2; exp_t e; } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] d_key = '0;
  pt_t        c1_in = '0, c2_in = '0;
  logic [2:0] x_pt, y_pt, z_pt;
  logic       pt_inf, busy, ready;

  int   n_chk = 0, n_err = 0, n_done = 0, done_cyc = 0, cyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ecc_decrypt_core #(.N(3), .K(4)) dut (
    .clk(clk), .reset(rst), .start(start), .d_key(d_key),
    .x_C1(c1_in.x), .y_C1(c1_in.y), .z_C1(c1_in.z),
    .x_C2(c2_in.x), .y_C2(c2_in.y), .z_C2(c2_in.z),
    .x_Plaintext(x_pt), .y_Plaintext(y_pt), .z_Plaintext(z_pt),
    .pt_inf(pt_inf), .busy(busy), .Decryption_ready(ready)
  );

  // golden-model point unit
  op_e        g_op = OP_ADD;
  pt_t        g_a = '0, g_b = '0;
  logic [2:0] g_x, g_y, g_z;
  ec_point_unit #(.N(3)) g_pu (
    .op(g_op), .X0(g_a.x), .Y0(g_a.y), .Z0(g_a.z),
    .X1(g_b.x), .Y1(g_b.y), .Z1(g_b.z), .X2(g_x), .Y2(g_y), .Z2(g_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pu(input op_e op, input pt_t a, input pt_t b, output pt_t r);
    g_op = op; g_a = a; g_b = b;
    #1;
    r = {g_x, g_y, g_z};
  endtask

  task automatic golden(input logic [3:0] d, input pt_t c1, input pt_t c2, output exp_t e);
    pt_t q, t, rq;
    logic inf;
    q = '0; inf = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (!inf) begin pu(OP_DOUBLE, q, q, t); q = t; inf = (t.z == 0); end
      if (d[i]) begin
        if (inf) begin q = c1; inf = (c1.z == 0); end
        else begin pu(OP_ADD, q, c1, t); q = t; inf = (t.z == 0); end
      end
    end
    rq = q; rq.y = q.x ^ q.y;
    if (inf && c2.z == 0)  begin e.r = '0; e.inf = 1'b1; end
    else if (inf)          begin e.r = c2; e.inf = 1'b0; end
    else if (c2.z == 0)    begin e.r = rq; e.inf = 1'b0; end
    else begin pu(OP_ADD, c2, rq, t); e.r = t; e.inf = (t.z == 0); end
  endtask

  always @(negedge clk) begin
    if (!rst && ready) begin
      exp_t e;
      n_done++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 0);
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("x_pt", 32'(x_pt), 32'(e.r.x));
        chk("y_pt", 32'(y_pt), 32'(e.r.y));
        chk("z_pt", 32'(z_pt), 32'(e.r.z));
        chk("pt_inf", 32'(pt_inf), 32'(e.inf));
      end
    end
  end

  task automatic wait_done(input int d0, input string name);
    for (int k = 0; k < 40; k++) begin
      if (n_done != d0) break;
      @(posedge clk);
    end
    if (n_done == d0) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic run_op(input logic [3:0] d, input pt_t c1, input pt_t c2,
                        input exp_t e, input string name);
    int d0, acc;
    @(negedge clk);
    d_key = d; c1_in = c1; c2_in = c2; start = 1'b1;
    exp_q.push_back(e);
    d0 = n_done;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    c1_in = 9'($urandom); c2_in = 9'($urandom); d_key = 4'($urandom);
    chk({name, "_busy"}, 32'(busy), 1);
    wait_done(d0, name);
    chk({name, "_latency"}, 32'(done_cyc - acc), 9);
  endtask

  vec_t vt[6];
  exp_t eg;
  int   d0, acc, t1;

  initial begin
    vt[0] = '{4'd0, 9'o351, 9'o621, '{9'o621, 1'b0}};
    vt[1] = '{4'd1, 9'o351, 9'o010, '{9'o361, 1'b0}};
    vt[2] = '{4'd0, 9'o351, 9'o010, '{9'o000, 1'b1}};
    vt[3] = '{4'd2, 9'o351, 9'o010, '{9'o424, 1'b0}};
    vt[4] = '{4'd5, 9'o120, 9'o732, '{9'o732, 1'b0}};
    vt[5] = '{4'd2, 9'o041, 9'o511, '{9'o511, 1'b0}};

    #12;
    chk("rst_x", 32'(x_pt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_inf", 32'(pt_inf), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vt[i].d, vt[i].c1, vt[i].c2, vt[i].e, $sformatf("vec%0d", i));

    // full key against golden model, then empty key with same operands
    golden(4'hF, 9'o351, 9'o621, eg);
    run_op(4'hF, 9'o351, 9'o621, eg, "d15");
    run_op(4'h0, 9'o351, 9'o621, '{9'o621, 1'b0}, "d0");

    // start pulses while busy must be ignored
    @(negedge clk);
    d_key = 4'd0; c1_in = 9'o351; c2_in = 9'o621; start = 1'b1;
    exp_q.push_back('{9'o621, 1'b0});
    d0 = n_done;
    @(posedge clk); #1 start = 1'b0; acc = cyc;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; d_key = 4'd1; c2_in = 9'o111;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, "ignore");
    chk("ignore_latency", 32'(done_cyc - acc), 9);
    repeat (15) @(posedge clk);
    chk("ignore_one_done", 32'(n_done - d0), 1);

    // reset mid-operation; no expectation queued for the aborted op
    @(negedge clk);
    d_key = 4'd5; c1_in = 9'o351; c2_in = 9'o621; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_x", 32'(x_pt), 0);
    chk("mid_rst_y", 32'(y_pt), 0);
    chk("mid_rst_z", 32'(z_pt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(ready), 0);
    @(negedge clk); rst = 1'b0;
    run_op(4'd0, 9'o351, 9'o273, '{9'o273, 1'b0}, "post_rst");

    // start held through done: back-to-back ops
    @(negedge clk);
    d_key = 4'd0; c1_in = 9'o351; c2_in = 9'o555; start = 1'b1;
    exp_q.push_back('{9'o555, 1'b0});
    d0 = n_done;
    @(posedge clk); #1 acc = cyc;
    d_key = 4'd1; c1_in = 9'o351; c2_in = 9'o010;
    exp_q.push_back('{9'o361, 1'b0});
    wait_done(d0, "b2b_first");
    t1 = done_cyc;
    #1 start = 1'b0;
    chk("b2b_latency", 32'(t1 - acc), 9);
    wait_done(d0 + 1, "b2b_second");
    chk("b2b_spacing", 32'(done_cyc - t1), 10);

    repeat (12) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
